// File: rtl/camera_sensor_emu.sv
// Parallel camera sensor emulator: vsync/href/pixdata framing with selectable test patterns.
// All outputs are registered copies of the next-state decode, so no input reaches an output combinationally.
module camera_sensor_emu #(
  parameter int HACT   = 10,
  parameter int VLINES = 1,
  parameter int VPRE   = 1,
  parameter int HBLANK = 1,
  parameter int VBLANK = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pat_sel,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  pixdata,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, PRE, ACT, HBLK, VBLK} state_t;

  localparam logic [15:0] HACT_LAST   = 16'(HACT - 1);
  localparam logic [15:0] VLINES_LAST = 16'(VLINES - 1);
  localparam logic [15:0] VPRE_LAST   = 16'(VPRE - 1);
  localparam logic [15:0] HBLANK_LAST = 16'(HBLANK - 1);
  localparam logic [15:0] VBLANK_LAST = 16'(VBLANK - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] x_reg, x_next;
  logic [15:0] y_reg, y_next;
  logic [1:0]  pat_reg, pat_next;
  logic        start_ok_reg;
  logic        vsync_reg, href_reg, frame_done_reg;
  logic [7:0]  pix_reg, pix_next;
  logic [15:0] frame_cnt_reg;
  logic        frame_end;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    pat_next   = pat_reg;
    case (state_reg)
      IDLE: begin
        // start_ok_reg holds off the first frame for one edge after reset release
        if (enable && start_ok_reg) begin
          state_next = PRE;
          cnt_next   = 16'd0;
          x_next     = 16'd0;
          y_next     = 16'd0;
          pat_next   = pat_sel;
        end
      end
      PRE: begin
        if (cnt_reg == VPRE_LAST) begin
          state_next = ACT;
          cnt_next   = 16'd0;
          x_next     = 16'd0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ACT: begin
        if (x_reg == HACT_LAST) begin
          state_next = HBLK;
          cnt_next   = 16'd0;
        end else begin
          x_next = x_reg + 16'd1;
        end
      end
      HBLK: begin
        if (cnt_reg == HBLANK_LAST) begin
          cnt_next = 16'd0;
          if (y_reg < VLINES_LAST) begin
            state_next = ACT;
            x_next     = 16'd0;
            y_next     = y_reg + 16'd1;
          end else begin
            state_next = VBLK;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      VBLK: begin
        if (cnt_reg == VBLANK_LAST) begin
          cnt_next = 16'd0;
          if (enable) begin
            state_next = PRE;
            x_next     = 16'd0;
            y_next     = 16'd0;
            pat_next   = pat_sel;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel byte is computed from next-cycle counters so it lines up with the registered href
  always_comb begin
    pix_next = 8'h00;
    if (state_next == ACT) begin
      case (pat_next)
        2'd0:    pix_next = x_next[7:0];
        2'd1:    pix_next = y_next[7:0];
        2'd2:    pix_next = 8'hA5;
        default: pix_next = (x_next[3] ^ y_next[3]) ? 8'hFF : 8'h00;
      endcase
    end
  end

  assign frame_end = (state_next == VBLK) && (state_reg != VBLK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 16'd0;
      x_reg          <= 16'd0;
      y_reg          <= 16'd0;
      pat_reg        <= 2'd0;
      start_ok_reg   <= 1'b0;
      vsync_reg      <= 1'b0;
      href_reg       <= 1'b0;
      pix_reg        <= 8'h00;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= 16'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      pat_reg        <= pat_next;
      start_ok_reg   <= 1'b1;
      vsync_reg      <= (state_next == PRE) || (state_next == ACT) || (state_next == HBLK);
      href_reg       <= (state_next == ACT);
      pix_reg        <= pix_next;
      frame_done_reg <= frame_end;
      if (frame_end) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign vsync      = vsync_reg;
  assign href       = href_reg;
  assign pixdata    = pix_reg;
  assign frame_done = frame_done_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_camera_sensor_emu.sv
// Directed bench for camera_sensor_emu: one default-parameter instance and one 4x3-line instance.
// Outputs are sampled on the falling edge; each captured frame prints one summary line.
module tb_camera_sensor_emu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, vs_a, hr_a, fd_a;
  logic [1:0]  pat_a;
  logic [7:0]  px_a;
  logic [15:0] fc_a;
  logic        rst_b, en_b, vs_b, hr_b, fd_b;
  logic [1:0]  pat_b;
  logic [7:0]  px_b;
  logic [15:0] fc_b;

  camera_sensor_emu dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .pat_sel(pat_a),
    .vsync(vs_a), .href(hr_a), .pixdata(px_a), .frame_done(fd_a), .frame_cnt(fc_a)
  );

  camera_sensor_emu #(.HACT(4), .VLINES(3), .HBLANK(2)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .pat_sel(pat_b),
    .vsync(vs_b), .href(hr_b), .pixdata(px_b), .frame_done(fd_b), .frame_cnt(fc_b)
  );

  logic        use_b;
  logic        o_vsync, o_href, o_frame_done;
  logic [7:0]  o_pixdata;
  logic [15:0] o_frame_cnt;
  assign o_vsync      = use_b ? vs_b : vs_a;
  assign o_href       = use_b ? hr_b : hr_a;
  assign o_pixdata    = use_b ? px_b : px_a;
  assign o_frame_done = use_b ? fd_b : fd_a;
  assign o_frame_cnt  = use_b ? fc_b : fc_a;

  int vectors, miscompares, href_viol;
  logic [7:0] pix_q[$];
  int burst_q[$];
  int gap_q[$];
  int vs_len, low_run, gap_seen, n_done_in, bad_pix;
  logic fd_at_fall, fd_after;
  logic [15:0] cnt_at_fall;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if ((hr_a && !vs_a) || (hr_b && !vs_b)) href_viol++;
  end

  // act_kind 1: switch pat_a to 2 at vsync cycle act_at; act_kind 2: drop en_b there
  task automatic capture_frame(input int act_at, input int act_kind);
    int guard;
    int run;
    logic prev;
    guard = 0;
    run = 0;
    prev = 1'b0;
    pix_q.delete();
    burst_q.delete();
    gap_q.delete();
    do begin
      @(negedge clk);
      guard++;
      if (!o_vsync) low_run++;
    end while (!o_vsync && guard < 400);
    gap_seen = low_run;
    if (!o_vsync) begin
      check_val("frame_start_timeout", 32'd0, 32'd1);
      return;
    end
    vs_len = 0;
    n_done_in = 0;
    bad_pix = 0;
    while (o_vsync && vs_len < 400) begin
      vs_len++;
      if (o_frame_done) n_done_in++;
      if (!o_href && o_pixdata != 8'h00) bad_pix++;
      if (o_href) pix_q.push_back(o_pixdata);
      if (o_href == prev) begin
        run++;
      end else begin
        if (prev) burst_q.push_back(run);
        else if (burst_q.size() > 0) gap_q.push_back(run);
        run = 1;
        prev = o_href;
      end
      if (vs_len == act_at) begin
        if (act_kind == 1) pat_a = 2'd2;
        else if (act_kind == 2) en_b = 1'b0;
      end
      @(negedge clk);
    end
    if (prev) burst_q.push_back(run);
    fd_at_fall  = o_frame_done;
    cnt_at_fall = o_frame_cnt;
    @(negedge clk);
    fd_after = o_frame_done;
    low_run  = 2;
  endtask

  task automatic check_frame(input string tag, input int exp_vs, input int exp_bursts,
                             input logic [15:0] exp_cnt);
    $display("frame %s: vsync %0d cycles, %0d href bursts, %0d bytes, frame_cnt %0h",
             tag, vs_len, burst_q.size(), pix_q.size(), cnt_at_fall);
    check_val({tag, "_vsync_len"}, 32'(vs_len), 32'(exp_vs));
    check_val({tag, "_bursts"}, 32'(burst_q.size()), 32'(exp_bursts));
    check_val({tag, "_done_at_fall"}, 32'(fd_at_fall), 32'd1);
    check_val({tag, "_done_after"}, 32'(fd_after), 32'd0);
    check_val({tag, "_done_in_frame"}, 32'(n_done_in), 32'd0);
    check_val({tag, "_frame_cnt"}, 32'(cnt_at_fall), 32'(exp_cnt));
    check_val({tag, "_pix_outside_href"}, 32'(bad_pix), 32'd0);
  endtask

  task automatic check_ramp(input string tag);
    check_val({tag, "_nbytes"}, 32'(pix_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < pix_q.size()) check_val({tag, "_ramp"}, 32'(pix_q[i]), 32'(i));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int highs;
    vectors = 0; miscompares = 0; href_viol = 0;
    use_b = 1'b0; low_run = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b1; en_b = 1'b1;
    pat_a = 2'd0; pat_b = 2'd1;
    repeat (3) @(negedge clk);
    check_val("rst_vsync", 32'(vs_a), 32'd0);
    check_val("rst_href", 32'(hr_a), 32'd0);
    check_val("rst_pixdata", 32'(px_a), 32'd0);
    check_val("rst_frame_done", 32'(fd_a), 32'd0);
    check_val("rst_frame_cnt", 32'(fc_a), 32'd0);

    rst_a = 1'b0;
    @(negedge clk);
    check_val("first_edge_no_pre", 32'(vs_a), 32'd0);

    capture_frame(0, 0);
    check_frame("a1", 12, 1, 16'd1);
    check_ramp("a1");

    capture_frame(3, 1);
    check_frame("a2", 12, 1, 16'd2);
    check_val("a2_vblank_len", 32'(gap_seen), 32'd5);
    check_ramp("a2");

    capture_frame(0, 0);
    pat_a = 2'd0;
    check_frame("a3", 12, 1, 16'd3);
    check_val("a3_nbytes", 32'(pix_q.size()), 32'd10);
    for (int i = 0; i < pix_q.size(); i++) check_val("a3_fixed_a5", 32'(pix_q[i]), 32'hA5);

    guard = 0;
    while (!(hr_a && px_a == 8'd5) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("a4_reached_x5", 32'(hr_a && px_a == 8'd5), 32'd1);
    #2 rst_a = 1'b1;
    #1;
    check_val("midrst_vsync", 32'(vs_a), 32'd0);
    check_val("midrst_href", 32'(hr_a), 32'd0);
    check_val("midrst_pixdata", 32'(px_a), 32'd0);
    check_val("midrst_frame_cnt", 32'(fc_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    capture_frame(0, 0);
    check_frame("a5", 12, 1, 16'd1);
    check_ramp("a5");

    force dut_a.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_cnt_reg;
    capture_frame(0, 0);
    check_frame("a6_wrap", 12, 1, 16'h0000);

    use_b = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    capture_frame(0, 0);
    check_frame("b1", 19, 3, 16'd1);
    for (int i = 0; i < burst_q.size(); i++) check_val("b1_burst_len", 32'(burst_q[i]), 32'd4);
    check_val("b1_ngaps", 32'(gap_q.size()), 32'd2);
    for (int i = 0; i < gap_q.size(); i++) check_val("b1_gap_len", 32'(gap_q[i]), 32'd2);
    check_val("b1_nbytes", 32'(pix_q.size()), 32'd12);
    for (int i = 0; i < pix_q.size(); i++) check_val("b1_line_pix", 32'(pix_q[i]), 32'(i / 4));

    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    capture_frame(8, 2);
    check_frame("b2_drop", 19, 3, 16'd1);
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (vs_b || hr_b) highs++;
    end
    check_val("b2_idle_no_frame", 32'(highs), 32'd0);
    check_val("b2_idle_pixdata", 32'(px_b), 32'd0);
    check_val("b2_idle_frame_done", 32'(fd_b), 32'd0);
    check_val("b2_idle_frame_cnt", 32'(fc_b), 32'd1);

    check_val("href_without_vsync", 32'(href_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
